// File: rtl/l2_tcdm_interleaved_mem.sv
// -----------------------------------------------------------------------------
// l2_tcdm_interleaved_mem
//
// Multi-master, word-interleaved, multi-bank L2 scratch memory with TCDM/lint
// slave ports. Each bank has its own round-robin arbiter. Responses come back
// exactly one cycle after the grant.
//
// Optional feature macro: L2_TCDM_INIT_ZERO_EN
//   defined   - after reset release an init FSM (IDLE -> SWEEP -> DONE) zeroes
//               one row of every bank per cycle; init_done_o rises when the
//               sweep has finished.
//   undefined - no init FSM; init_done_o follows rst_ni.
//
// Ports (per-master signals are packed arrays indexed by master):
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   req_i        request
//   add_i        byte address
//   wen_i        1 = read, 0 = write
//   wdata_i      write data
//   be_i         byte enables (writes only)
//   gnt_o        grant, combinational from this cycle's requests
//   r_valid_o    response valid (cycle after grant)
//   r_rdata_o    read data
//   r_opc_o      1 = error response (out-of-range address)
//   init_done_o  memory is accepting requests
// -----------------------------------------------------------------------------
`default_nettype none

module l2_tcdm_interleaved_mem #(
  parameter int unsigned NB_MASTERS = 2,
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_WORDS = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NB_MASTERS-1:0]         req_i,
  input  logic [NB_MASTERS-1:0][31:0]   add_i,
  input  logic [NB_MASTERS-1:0]         wen_i,
  input  logic [NB_MASTERS-1:0][31:0]   wdata_i,
  input  logic [NB_MASTERS-1:0][3:0]    be_i,
  output logic [NB_MASTERS-1:0]         gnt_o,
  output logic [NB_MASTERS-1:0]         r_valid_o,
  output logic [NB_MASTERS-1:0][31:0]   r_rdata_o,
  output logic [NB_MASTERS-1:0]         r_opc_o,
  output logic                          init_done_o
);

  localparam int unsigned BANK_BITS   = (NB_BANKS   > 1) ? $clog2(NB_BANKS)   : 1;
  localparam int unsigned ROW_BITS    = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
  localparam int unsigned MST_BITS    = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam logic [31:0] TOTAL_WORDS = 32'(NB_BANKS * BANK_WORDS);

  logic [31:0] mem [NB_BANKS][BANK_WORDS];

  // Requests are only accepted out of reset and once initialisation is done.
  logic accept;

  // ---------------------------------------------------------------------------
  // Optional zero-initialisation sweep
  // ---------------------------------------------------------------------------
`ifdef L2_TCDM_INIT_ZERO_EN
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} init_state_e;

  init_state_e         init_state;
  logic [ROW_BITS-1:0] sweep_row;
  logic                init_done_q;
  logic                sweep_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      init_state  <= IDLE;
      sweep_row   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (init_state)
        IDLE: begin
          init_state <= SWEEP;
          sweep_row  <= '0;
        end
        SWEEP: begin
          if (sweep_row == ROW_BITS'(BANK_WORDS - 1)) begin
            init_state  <= DONE;
            init_done_q <= 1'b1;
          end else begin
            sweep_row <= sweep_row + 1'b1;
          end
        end
        default: init_state <= DONE;
      endcase
    end
  end

  assign sweep_we = rst_ni && (init_state == SWEEP);
  assign accept   = rst_ni && init_done_q;
`else
  assign accept   = rst_ni;
`endif

  assign init_done_o = accept;

  // ---------------------------------------------------------------------------
  // Address decode: word index, bank, row, range check
  // ---------------------------------------------------------------------------
  logic [NB_MASTERS-1:0][31:0]          word;
  logic [NB_MASTERS-1:0]                in_range;
  logic [NB_MASTERS-1:0][BANK_BITS-1:0] bank_idx;
  logic [NB_MASTERS-1:0][ROW_BITS-1:0]  row_idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    word     = '0;
    in_range = '0;
    bank_idx = '0;
    row_idx  = '0;
    for (int m = 0; m < NB_MASTERS; m++) begin
      // The subtraction wraps for addresses below BASE_ADDR; the explicit
      // lower-bound compare rejects those.
      word[m]     = (add_i[m] - BASE_ADDR) >> 2;
      in_range[m] = (add_i[m] >= BASE_ADDR) && (word[m] < TOTAL_WORDS);
      bank_idx[m] = BANK_BITS'(word[m] % NB_BANKS);
      row_idx[m]  = ROW_BITS'(word[m] / NB_BANKS);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank round-robin arbitration
  // ---------------------------------------------------------------------------
  logic [NB_BANKS-1:0][MST_BITS-1:0] ptr;
  logic [NB_BANKS-1:0][MST_BITS-1:0] win_idx;
  logic [NB_BANKS-1:0]               win_vld;
  logic [NB_MASTERS-1:0]             gnt;

  always_comb begin
    win_idx = '0;
    win_vld = '0;
    gnt     = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      // First pass scans masters ptr..N-1, second pass wraps to 0..ptr-1.
      for (int m = 0; m < NB_MASTERS; m++) begin
        if (!win_vld[b] && (m >= int'(ptr[b])) && req_i[m] && in_range[m] &&
            (bank_idx[m] == BANK_BITS'(b))) begin
          win_vld[b] = 1'b1;
          win_idx[b] = MST_BITS'(m);
        end
      end
      for (int m = 0; m < NB_MASTERS; m++) begin
        if (!win_vld[b] && req_i[m] && in_range[m] &&
            (bank_idx[m] == BANK_BITS'(b))) begin
          win_vld[b] = 1'b1;
          win_idx[b] = MST_BITS'(m);
        end
      end
    end
    if (accept) begin
      // Out-of-range requests bypass arbitration entirely.
      for (int m = 0; m < NB_MASTERS; m++) begin
        if (req_i[m] && !in_range[m]) gnt[m] = 1'b1;
      end
      for (int b = 0; b < NB_BANKS; b++) begin
        if (win_vld[b]) gnt[win_idx[b]] = 1'b1;
      end
    end
  end

  assign gnt_o = gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (accept) begin
      for (int b = 0; b < NB_BANKS; b++) begin
        if (win_vld[b]) begin
          ptr[b] <= (win_idx[b] == MST_BITS'(NB_MASTERS - 1)) ? '0 : win_idx[b] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bank storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; a reset would turn it into flops instead of
  // a RAM macro. Zeroing is the optional sweep's job.
  always_ff @(posedge clk_i) begin
`ifdef L2_TCDM_INIT_ZERO_EN
    if (sweep_we) begin
      for (int b = 0; b < NB_BANKS; b++) mem[b][sweep_row] <= '0;
    end else
`endif
    if (accept) begin
      for (int b = 0; b < NB_BANKS; b++) begin
        if (win_vld[b] && !wen_i[win_idx[b]]) begin
          for (int by = 0; by < 4; by++) begin
            if (be_i[win_idx[b]][by]) begin
              mem[b][row_idx[win_idx[b]]][8*by +: 8] <= wdata_i[win_idx[b]][8*by +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response path: one-cycle latency
  // ---------------------------------------------------------------------------
  logic [NB_MASTERS-1:0]       r_valid_q;
  logic [NB_MASTERS-1:0]       r_opc_q;
  logic [NB_MASTERS-1:0][31:0] r_rdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      r_opc_q   <= '0;
      r_rdata_q <= '0;
    end else begin
      for (int m = 0; m < NB_MASTERS; m++) begin
        r_valid_q[m] <= gnt[m];
        r_opc_q[m]   <= gnt[m] && !in_range[m];
        // A bank serves one master per cycle, so this pre-edge value is the
        // row content at the end of the grant cycle.
        r_rdata_q[m] <= (gnt[m] && in_range[m] && wen_i[m]) ?
                        mem[bank_idx[m]][row_idx[m]] : '0;
      end
    end
  end

  // A response due in the first reset cycle is dropped, so the registered
  // outputs are masked by the reset input itself.
  assign r_valid_o = r_valid_q & {NB_MASTERS{rst_ni}};
  assign r_opc_o   = r_opc_q & {NB_MASTERS{rst_ni}};
  assign r_rdata_o = rst_ni ? r_rdata_q : '0;

endmodule

`default_nettype wire
